// File: rtl/adder_share_arb.sv
// Two-requester round-robin arbiter in front of one shared 32-bit add/subtract unit.
// Results land in a one-entry response slot; per-requester acceptance counters are kept for debug.

module adder32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        alufn,
    output logic [31:0] sum,
    output logic        z,
    output logic        v,
    output logic        n
);
    logic [31:0] b_eff;

    // Subtract is A + ~B + 1; overflow is judged on the effective addend ~B.
    always_comb begin
        b_eff = alufn ? ~b : b;
        sum   = a + b_eff + {31'd0, alufn};
        z     = (sum == 32'd0);
        n     = sum[31];
        v     = (a[31] == b_eff[31]) && (sum[31] != a[31]);
    end
endmodule

module adder_share_arb #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [31:0]      req0_a,
    input  logic [31:0]      req0_b,
    input  logic             req0_sub,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [31:0]      req1_a,
    input  logic [31:0]      req1_b,
    input  logic             req1_sub,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [31:0]      rsp_sum,
    output logic             rsp_z,
    output logic             rsp_v,
    output logic             rsp_n,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_id_q, rsp_id_d;
    logic [31:0]      rsp_sum_q, rsp_sum_d;
    logic             rsp_z_q, rsp_z_d;
    logic             rsp_v_q, rsp_v_d;
    logic             rsp_n_q, rsp_n_d;
    logic             ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt0_q, cnt0_d;
    logic [CNT_W-1:0] cnt1_q, cnt1_d;

    logic             slot_free, pick0, pick1, acc;
    logic [31:0]      op_a, op_b, add_sum;
    logic             op_sub, add_z, add_v, add_n;

    adder32 u_adder (
        .a     (op_a),
        .b     (op_b),
        .alufn (op_sub),
        .sum   (add_sum),
        .z     (add_z),
        .v     (add_v),
        .n     (add_n)
    );

    // Grant uses only valids, rsp_ready and state so operands never reach the readies.
    always_comb begin
        slot_free  = !rsp_valid_q || rsp_ready;
        pick1      = req1_valid && (!req0_valid || ptr_q);
        pick0      = req0_valid && !pick1;
        req0_ready = rst_n && slot_free && pick0;
        req1_ready = rst_n && slot_free && pick1;
        acc        = req0_ready || req1_ready;
        op_a       = pick1 ? req1_a   : req0_a;
        op_b       = pick1 ? req1_b   : req0_b;
        op_sub     = pick1 ? req1_sub : req0_sub;
    end

    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_sum_d   = rsp_sum_q;
        rsp_z_d     = rsp_z_q;
        rsp_v_d     = rsp_v_q;
        rsp_n_d     = rsp_n_q;
        ptr_d       = ptr_q;
        cnt0_d      = cnt0_q;
        cnt1_d      = cnt1_q;
        if (acc) begin
            rsp_valid_d = 1'b1;
            rsp_id_d    = pick1;
            rsp_sum_d   = add_sum;
            rsp_z_d     = add_z;
            rsp_v_d     = add_v;
            rsp_n_d     = add_n;
            ptr_d       = !pick1;
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
        if (req0_ready) cnt0_d = cnt0_q + CNT_W'(1);
        if (req1_ready) cnt1_d = cnt1_q + CNT_W'(1);
        if (clr_cnt) begin
            cnt0_d = '0;
            cnt1_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_sum_q   <= 32'd0;
            rsp_z_q     <= 1'b0;
            rsp_v_q     <= 1'b0;
            rsp_n_q     <= 1'b0;
            ptr_q       <= 1'b0;
            cnt0_q      <= '0;
            cnt1_q      <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_sum_q   <= rsp_sum_d;
            rsp_z_q     <= rsp_z_d;
            rsp_v_q     <= rsp_v_d;
            rsp_n_q     <= rsp_n_d;
            ptr_q       <= ptr_d;
            cnt0_q      <= cnt0_d;
            cnt1_q      <= cnt1_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_z     = rsp_z_q;
    assign rsp_v     = rsp_v_q;
    assign rsp_n     = rsp_n_q;
    assign cnt0      = cnt0_q;
    assign cnt1      = cnt1_q;
endmodule

// File: tb/tb_adder_share_arb.sv
// Bench for adder_share_arb: directed scenarios followed by randomized traffic,
// compared against an arithmetic reference model of the arbiter and response slot.

module tb_adder_share_arb;
    localparam int CNT_W = 2;
    localparam longint MAXS = 64'sd2147483647;
    localparam longint MINS = -64'sd2147483648;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req0_valid, req0_ready, req0_sub;
    logic [31:0]      req0_a, req0_b;
    logic             req1_valid, req1_ready, req1_sub;
    logic [31:0]      req1_a, req1_b;
    logic             rsp_valid, rsp_ready, rsp_id, rsp_z, rsp_v, rsp_n;
    logic [31:0]      rsp_sum;
    logic             clr_cnt;
    logic [CNT_W-1:0] cnt0, cnt1;

    adder_share_arb #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_sub   (req0_sub),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_sub   (req1_sub),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_sum    (rsp_sum),
        .rsp_z      (rsp_z),
        .rsp_v      (rsp_v),
        .rsp_n      (rsp_n),
        .clr_cnt    (clr_cnt),
        .cnt0       (cnt0),
        .cnt1       (cnt1)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // Reference model: the slot contents, whose turn it is, and acceptance counts.
    bit          m_vld, m_id, m_z, m_v, m_n, m_turn;
    logic [31:0] m_sum;
    int          m_cnt0, m_cnt1;
    bit          acc0, acc1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_vld = 0; m_id = 0; m_sum = 0; m_z = 0; m_v = 0; m_n = 0;
        m_turn = 0; m_cnt0 = 0; m_cnt1 = 0;
    endtask

    function automatic void model_op(input logic [31:0] a, input logic [31:0] b, input bit sub,
                                     output logic [31:0] s, output bit v);
        longint sa, sb, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r  = sub ? sa - sb : sa + sb;
        s  = r[31:0];
        v  = (r > MAXS) || (r < MINS);
    endfunction

    task automatic drive(input bit v0, input logic [31:0] a0, input logic [31:0] b0, input bit s0,
                         input bit v1, input logic [31:0] a1, input logic [31:0] b1, input bit s1,
                         input bit rr, input bit clr);
        req0_valid = v0; req0_a = a0; req0_b = b0; req0_sub = s0;
        req1_valid = v1; req1_a = a1; req1_b = b1; req1_sub = s1;
        rsp_ready = rr; clr_cnt = clr;
    endtask

    // Called just after a falling edge with inputs set; returns just after the next falling edge.
    task automatic step();
        bit free, g0, g1;
        logic [31:0] s;
        bit v;
        #1;
        free = !m_vld || rsp_ready;
        g0 = req0_valid && (!req1_valid || m_turn == 1'b0);
        g1 = req1_valid && !g0;
        acc0 = free && g0;
        acc1 = free && g1;
        check("req0_ready", {31'd0, req0_ready}, {31'd0, acc0});
        check("req1_ready", {31'd0, req1_ready}, {31'd0, acc1});
        @(posedge clk);
        if (acc0 || acc1) begin
            if (acc1) model_op(req1_a, req1_b, req1_sub, s, v);
            else      model_op(req0_a, req0_b, req0_sub, s, v);
            m_vld = 1; m_id = acc1; m_sum = s; m_v = v;
            m_z = (s == 32'd0); m_n = s[31];
            m_turn = !acc1;
            if (acc0) m_cnt0 = (m_cnt0 + 1) % (1 << CNT_W);
            if (acc1) m_cnt1 = (m_cnt1 + 1) % (1 << CNT_W);
        end else if (rsp_ready) begin
            m_vld = 0;
        end
        if (clr_cnt) begin
            m_cnt0 = 0; m_cnt1 = 0;
        end
        #1;
        check("rsp_valid", {31'd0, rsp_valid}, {31'd0, m_vld});
        check("rsp_id",    {31'd0, rsp_id},    {31'd0, m_id});
        check("rsp_sum",   rsp_sum,            m_sum);
        check("rsp_zvn",   {29'd0, rsp_z, rsp_v, rsp_n}, {29'd0, m_z, m_v, m_n});
        check("cnt0",      32'(cnt0),          32'(m_cnt0));
        check("cnt1",      32'(cnt1),          32'(m_cnt1));
        @(negedge clk);
    endtask

    function automatic logic [31:0] rand_operand();
        logic [31:0] r;
        case ($urandom_range(0, 7))
            0: r = 32'h7FFF_FFFF;
            1: r = 32'h8000_0000;
            2: r = 32'h0000_0000;
            3: r = 32'hFFFF_FFFF;
            default: r = $urandom;
        endcase
        return r;
    endfunction

    bit          p_v[2];
    logic [31:0] p_a[2], p_b[2];
    bit          p_s[2];

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        model_reset();
        repeat (2) @(negedge clk);
        drive(1, 32'd1, 32'd1, 0, 1, 32'd2, 32'd2, 0, 1, 0);
        #1;
        check("rst_ready0", {31'd0, req0_ready}, 32'd0);
        check("rst_ready1", {31'd0, req1_ready}, 32'd0);
        check("rst_valid",  {31'd0, rsp_valid},  32'd0);
        check("rst_sum",    rsp_sum,             32'd0);
        check("rst_cnt",    {30'd0, cnt0 | cnt1}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Simple add from requester 0
        drive(1, 32'd5, 32'd7, 0, 0, 0, 0, 0, 1, 0);
        step();
        check("t1_sum",  rsp_sum, 32'd12);
        check("t1_id",   {31'd0, rsp_id}, 32'd0);
        check("t1_zvn",  {29'd0, rsp_z, rsp_v, rsp_n}, 32'd0);
        check("t1_cnt0", 32'(cnt0), 32'd1);

        // Signed overflow, then subtract to zero, both from requester 1
        drive(0, 0, 0, 0, 1, 32'h7FFF_FFFF, 32'd1, 0, 1, 0);
        step();
        check("t2_sum", rsp_sum, 32'h8000_0000);
        check("t2_zvn", {29'd0, rsp_z, rsp_v, rsp_n}, 32'b011);
        drive(0, 0, 0, 0, 1, 32'd9, 32'd9, 1, 1, 0);
        step();
        check("t3_sum", rsp_sum, 32'd0);
        check("t3_zvn", {29'd0, rsp_z, rsp_v, rsp_n}, 32'b100);

        // Round-robin under continuous contention
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        step();
        for (int k = 0; k < 6; k++) begin
            drive(1, 32'(k), 32'd100, 0, 1, 32'(k), 32'd200, 1, 1, 0);
            step();
            check("alt_id", {31'd0, rsp_id}, 32'(k % 2));
        end
        check("alt_cnt0", 32'(cnt0), 32'd3);
        check("alt_cnt1", 32'(cnt1), 32'd3);

        // Backpressure holds the slot, then releases with no bubble
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        for (int k = 0; k < 3; k++) begin
            drive(1, 32'd11, 32'd22, 0, 1, 32'd33, 32'd44, 1, 0, 0);
            step();
        end
        drive(1, 32'd11, 32'd22, 0, 1, 32'd33, 32'd44, 1, 1, 0);
        step();
        check("bp_valid", {31'd0, rsp_valid}, 32'd1);

        // Asynchronous reset while a response is pending
        drive(1, 32'd1, 32'd2, 0, 1, 32'd3, 32'd4, 0, 0, 0);
        step();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("ar_valid",  {31'd0, rsp_valid},  32'd0);
        check("ar_cnt",    {30'd0, cnt0 | cnt1}, 32'd0);
        check("ar_ready0", {31'd0, req0_ready}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 32'd10, 32'd20, 0, 1, 32'd30, 32'd40, 0, 1, 0);
        step();
        check("ar_first", {31'd0, rsp_id}, 32'd0);

        // Counter wrap and clear-beats-increment
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        step();
        for (int k = 0; k < 5; k++) begin
            drive(1, 32'(k), 32'd1, 0, 0, 0, 0, 0, 1, 0);
            step();
        end
        check("wrap_cnt0", 32'(cnt0), 32'd1);
        drive(1, 32'd40, 32'd2, 0, 0, 0, 0, 0, 1, 1);
        step();
        check("clr_cnt0",  32'(cnt0), 32'd0);
        check("clr_valid", {31'd0, rsp_valid}, 32'd1);
        check("clr_sum",   rsp_sum, 32'd42);

        // Randomized traffic with stable-until-accepted requesters
        p_v[0] = 0; p_v[1] = 0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (!p_v[i] && ($urandom_range(0, 2) != 0)) begin
                    p_v[i] = 1;
                    p_a[i] = rand_operand();
                    p_b[i] = rand_operand();
                    p_s[i] = $urandom_range(0, 1) == 1;
                end
            end
            drive(p_v[0], p_a[0], p_b[0], p_s[0], p_v[1], p_a[1], p_b[1], p_s[1],
                  $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0);
            step();
            if (acc0) p_v[0] = 0;
            if (acc1) p_v[1] = 0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/adder_share_arb.md
Name: adder_share_arb

Overview:
- Arbitrates one 32-bit add/subtract unit (adder32) between two requesters. Each requester uses a valid/ready handshake.
- Each accepted operation is computed combinationally, then registered into a one-entry response slot. The slot carries sum, Z/V/N flags and the requester ID.
- Sits between the two issuing units and the shared arithmetic datapath. Also keeps per-requester completion counters for debug and performance reads.

Parameters:
CNT_W, 16, width of each per-requester acceptance counter (wraps modulo 2^CNT_W)

Ports:
clk  input  1  single clock; all state updates on rising edge
rst_n  input  1  asynchronous, active-low reset
req0_valid  input  1  requester 0 has an operation
req0_ready  output  1  requester 0 operation accepted this cycle
req0_a  input  32  requester 0 operand A
req0_b  input  32  requester 0 operand B
req0_sub  input  1  requester 0: 0 = A+B, 1 = A-B
req1_valid  input  1  requester 1 has an operation
req1_ready  output  1  requester 1 operation accepted this cycle
req1_a  input  32  requester 1 operand A
req1_b  input  32  requester 1 operand B
req1_sub  input  1  requester 1: 0 = A+B, 1 = A-B
rsp_valid  output  1  response slot holds a result
rsp_ready  input  1  consumer takes response this cycle
rsp_id  output  1  requester that issued the response
rsp_sum  output  32  result, modulo 2^32
rsp_z  output  1  rsp_sum == 0
rsp_v  output  1  signed overflow of the selected operation
rsp_n  output  1  rsp_sum[31]
clr_cnt  input  1  synchronous clear of both counters
cnt0  output  CNT_W  operations accepted from requester 0
cnt1  output  CNT_W  operations accepted from requester 1

Behaviour:
- Reset (async, rst_n=0):
  - rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_z=0, rsp_v=0, rsp_n=0.
  - cnt0=cnt1=0; priority pointer=0 (requester 0 favoured).
  - reqX_ready=0 while rst_n=0.
  - A response pending at reset assertion is discarded.
- Slot availability: slot_free = !rsp_valid || rsp_ready.
- Grant:
  - Only one valid requester: it is granted.
  - Both valid: the requester named by the priority pointer is granted.
  - No valid requester: no grant.
- Ready: reqX_ready = slot_free && grant==X. At most one ready is high per cycle.
- Combinational paths: ready depends on reqX_valid, rsp_ready and state only. There is no path from operand or sub inputs to any ready.
- Acceptance = reqX_valid && reqX_ready.
- On acceptance at edge T:
  - Granted operands go through one shared adder32 instance: ALUFN = reqX_sub.
  - Slot is loaded: rsp_sum, Z, V, N from the adder; rsp_id = X; rsp_valid=1 visible after edge T (latency 1 cycle).
  - Priority pointer becomes the other requester (round-robin; a lone requester also flips it).
- Flag semantics:
  - V = 1 when both operands of the effective addition (A and B or ~B) have equal sign and the sum sign differs.
  - Subtract is A + ~B + 1.
- Back-to-back: if rsp_valid && rsp_ready and a request is accepted in the same cycle, the slot is overwritten with the new result and rsp_valid stays 1. Full throughput is 1 operation/cycle.
- Backpressure: rsp_valid && !rsp_ready holds rsp_* stable, forces both ready low and freezes the pointer.
- If rsp_ready=1 with no acceptance, rsp_valid clears next cycle. rsp data keeps its last value.
- Requesters must hold valid and operands stable until accepted. The block does not check this.
- Counters:
  - cntX increments on each requester-X acceptance and wraps from 2^CNT_W-1 to 0.
  - clr_cnt=1 sets both counters to 0 and takes priority over a same-cycle increment.
  - The acceptance itself still completes normally.
- No starvation: with both valid continuously and rsp_ready=1, grants alternate 0,1,0,1...

Test Plan:
- Reset, then req0 valid A=5, B=7, sub=0, rsp_ready=1 -> next cycle rsp_valid=1, id=0, sum=12, z=0, v=0, n=0; cnt0=1.
- req1 A=0x7FFFFFFF, B=1, sub=0 -> sum=0x80000000, v=1, n=1, z=0. Then req1 A=9, B=9, sub=1 -> sum=0, z=1, v=0, n=0.
- Both valid every cycle for 6 cycles, rsp_ready=1 -> rsp_id sequence 0,1,0,1,0,1 on consecutive cycles; cnt0=cnt1=3.
- Fill slot, hold rsp_ready=0 for 3 cycles with both requesters valid -> both ready=0, rsp_* unchanged. Raise rsp_ready -> same-cycle acceptance, new result next cycle with no bubble.
- Assert rst_n=0 mid-stream with rsp_valid=1 -> rsp_valid=0, counters 0, pointer 0 immediately (asynchronous). After release, simultaneous requests grant requester 0 first.
- CNT_W=2, 5 req0 acceptances -> cnt0=1 (wrap). Assert clr_cnt in the same cycle as an acceptance -> cnt0=0 and the response is still produced.
